uart_rx_fifo: RTL and testbench

UART receiver for the system's serial link. It receives 8N1 frames on uart_rxd and pushes each valid byte into a small first-word-fall-through FIFO. The CPU-side bus bridge drains the FIFO through a valid/ack pop handshake. It sits directly behind the uart_rxd pad, and its framing matches the clk_freq and uart_baud_rate parameters used at system level.

---
 rtl/uart_rx_fifo.sv | 144 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a small first-word-fall-through FIFO.
// Valid/ack pop: the head byte on rx_data is consumed on any edge where rx_ack and rx_avail are both high.
module uart_rx_fifo #(
  parameter int clk_freq       = 50000000,
  parameter int uart_baud_rate = 1152000,
  parameter int fifo_addr_w    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_avail,
  input  logic       rx_ack,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       rx_overrun,
  input  logic       err_clr
);

  localparam int divisor  = clk_freq / uart_baud_rate;
  localparam int half_div = divisor / 2;
  localparam int depth    = 1 << fifo_addr_w;
  localparam int cnt_w    = $clog2(divisor);
  localparam logic [cnt_w-1:0]       full_load = cnt_w'(divisor - 1);
  localparam logic [cnt_w-1:0]       half_load = cnt_w'(half_div - 1);
  localparam logic [fifo_addr_w:0]   depth_cnt = (fifo_addr_w + 1)'(depth);

  if (divisor < 4) begin : g_bad_divisor
    $error("uart_rx_fifo: clk_freq / uart_baud_rate must be at least 4");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t                 state;
  logic                   rxd_m, rxd_s, rxd_d;
  logic [cnt_w-1:0]       cnt;
  logic [2:0]             bitcnt;
  logic [7:0]             shreg;
  logic [7:0]             mem [depth];
  logic [fifo_addr_w-1:0] wr_ptr, rd_ptr;
  logic [fifo_addr_w:0]   count;
  logic                   fall, tick, push_req, pop, full, do_push;

  // Idle-high presets keep reset release from looking like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_d <= 1'b1;
    end else begin
      rxd_m <= uart_rxd;
      rxd_s <= rxd_m;
      rxd_d <= rxd_s;
    end
  end

  assign fall = rxd_d & ~rxd_s;
  assign tick = (cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bitcnt    <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      if (err_clr) frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            cnt   <= half_load;
            state <= START;
          end
        end
        START: begin
          if (!tick) cnt <= cnt - 1'b1;
          else if (rxd_s) state <= IDLE;
          else begin
            cnt    <= full_load;
            bitcnt <= '0;
            state  <= DATA;
          end
        end
        DATA: begin
          if (!tick) cnt <= cnt - 1'b1;
          else begin
            shreg  <= {rxd_s, shreg[7:1]};
            cnt    <= full_load;
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (!tick) cnt <= cnt - 1'b1;
          else if (rxd_s) state <= IDLE;
          else begin
            frame_err <= 1'b1;
            state     <= BRK;
          end
        end
        BRK: begin
          // A held-low line must return high before a new start bit counts.
          if (rxd_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rx_busy  = (state != IDLE);
  assign push_req = (state == STOP) && tick && rxd_s;
  assign pop      = rx_ack && rx_avail;
  assign full     = (count == depth_cnt);
  // When full, a simultaneous pop frees the slot the push lands in.
  assign do_push  = push_req && (!full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rx_overrun <= 1'b0;
      for (int i = 0; i < depth; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && full && !pop) rx_overrun <= 1'b1;
      else if (err_clr)             rx_overrun <= 1'b0;
    end
  end

  assign rx_avail = (count != '0);
  assign rx_data  = mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a frame table plus hand sequences for glitch, overrun,
// full-with-pop, and mid-frame reset; received bytes are scored against exp_q.
module tb_uart_rx_fifo;

  localparam int bit_clks = 43;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       rx_ack = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_avail, rx_busy, frame_err, rx_overrun;

  int checks = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_avail;
    logic       exp_ferr;
  } vec_t;
  vec_t vecs[6];

  uart_rx_fifo dut (
    .clk(clk), .rst(rst), .uart_rxd(uart_rxd),
    .rx_data(rx_data), .rx_avail(rx_avail), .rx_ack(rx_ack),
    .rx_busy(rx_busy), .frame_err(frame_err), .rx_overrun(rx_overrun),
    .err_clr(err_clr)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    @(negedge clk) uart_rxd = 1'b0;
    repeat (bit_clks) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      repeat (bit_clks) @(negedge clk);
    end
    uart_rxd = stop_bit;
    repeat (bit_clks) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (rx_busy === 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(name, (n < 5000), 1);
  endtask

  task automatic pop_check(input string name);
    logic [7:0] e;
    check({name, "_avail"}, rx_avail, 1);
    if (exp_q.size() == 0) begin
      checks++;
      fails++;
      $display("FAIL %s: got %0h with no byte expected", name, rx_data);
    end else begin
      e = exp_q.pop_front();
      check({name, "_data"}, rx_data, e);
    end
    rx_ack = 1'b1;
    @(negedge clk) rx_ack = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, busy_n;
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h5A, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'($urandom_range(0, 255)), 1'b1, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_avail", rx_avail, 0);
    check("rst_busy", rx_busy, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", rx_overrun, 0);
    check("rst_data", rx_data, 8'h00);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // A5 with latency measured from the start edge
    exp_q.push_back(8'hA5);
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        @(negedge clk);
        while (!rx_avail && lat < 600) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    check("a5_latency_window", (lat >= 405 && lat <= 415), 1);
    check("a5_ferr", frame_err, 0);
    pop_check("a5_pop");
    check("a5_empty_after_ack", rx_avail, 0);

    // Frame table
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].stop) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop);
      if (!vecs[i].stop) begin
        repeat (2 * bit_clks) @(negedge clk);
        check($sformatf("vec%0d_brk_busy", i), rx_busy, 1);
        uart_rxd = 1'b1;
        wait_idle($sformatf("vec%0d_idle", i));
      end
      check($sformatf("vec%0d_avail", i), rx_avail, vecs[i].exp_avail);
      check($sformatf("vec%0d_ferr", i), frame_err, vecs[i].exp_ferr);
      if (vecs[i].exp_avail) begin
        pop_check($sformatf("vec%0d_pop", i));
        check($sformatf("vec%0d_empty", i), rx_avail, 0);
      end
      if (vecs[i].exp_ferr) begin
        err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
        check($sformatf("vec%0d_ferr_clr", i), frame_err, 0);
      end
    end

    // 100 ns glitch on idle line
    busy_n = 0;
    @(negedge clk) uart_rxd = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (i == 5) uart_rxd = 1'b1;
      @(negedge clk);
      if (rx_busy) busy_n++;
    end
    check("glitch_busy_len", (busy_n >= 19 && busy_n <= 23), 1);
    check("glitch_avail", rx_avail, 0);
    check("glitch_ferr", frame_err, 0);

    // Overrun: five bytes into four slots
    for (int b = 1; b <= 5; b++) begin
      if (b <= 4) exp_q.push_back(8'(b));
      send_frame(8'(b), 1'b1);
    end
    check("ovr_flag", rx_overrun, 1);
    for (int i = 0; i < 4; i++) pop_check($sformatf("ovr_pop%0d", i));
    check("ovr_empty", rx_avail, 0);
    rx_ack = 1'b1;
    @(negedge clk) rx_ack = 1'b0;
    check("ack_while_empty", rx_avail, 0);
    err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    check("ovr_clr", rx_overrun, 0);

    // Full FIFO, pop in the exact push cycle of the fifth byte
    exp_q.push_back(8'h11); send_frame(8'h11, 1'b1);
    exp_q.push_back(8'h22); send_frame(8'h22, 1'b1);
    exp_q.push_back(8'h33); send_frame(8'h33, 1'b1);
    exp_q.push_back(8'h44); send_frame(8'h44, 1'b1);
    exp_q.push_back(8'h55);
    fork
      send_frame(8'h55, 1'b1);
      begin
        @(negedge clk);
        repeat (410) @(posedge clk);
        @(negedge clk);
        check("full_pop_head", rx_data, exp_q.pop_front());
        rx_ack = 1'b1;
        @(negedge clk) rx_ack = 1'b0;
      end
    join
    check("full_pop_no_ovr", rx_overrun, 0);
    for (int i = 0; i < 4; i++) pop_check($sformatf("full_pop%0d", i));
    check("full_pop_empty", rx_avail, 0);

    // Mid-frame reset with stale state present
    exp_q.push_back(8'h9C);
    send_frame(8'h9C, 1'b1);
    send_frame(8'h3C, 1'b0);
    repeat (10) @(negedge clk);
    uart_rxd = 1'b1;
    wait_idle("pre_rst_idle");
    check("pre_rst_ferr", frame_err, 1);
    @(negedge clk) uart_rxd = 1'b0;
    repeat (bit_clks) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (100) @(negedge clk);
    check("mid_data_busy", rx_busy, 1);
    rst = 1'b0;
    @(negedge clk);
    check("in_rst_avail", rx_avail, 0);
    check("in_rst_busy", rx_busy, 0);
    check("in_rst_ferr", frame_err, 0);
    check("in_rst_ovr", rx_overrun, 0);
    check("in_rst_data", rx_data, 8'h00);
    exp_q.delete();
    repeat (400) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    pop_check("post_rst_pop");
    check("post_rst_empty", rx_avail, 0);
    check("post_rst_busy", rx_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
